// File: rtl/bus_core_pkg.sv
// rtl/bus_core_pkg.sv - shared ISA constants and field positions for bus_core_seq
package bus_core_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_ALU  = 2'b01,
    OP_COPY = 2'b10,
    OP_JUMP = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_OR, ALU_NAND, ALU_NOR, ALU_AND, ALU_ADD, ALU_SUB, ALU_XOR, ALU_XNOR
  } alu_op_e;

  typedef enum logic [2:0] {
    CC_NEVER, CC_EQ, CC_LT, CC_LE, CC_ALWAYS, CC_NE, CC_GE, CC_GT
  } cond_e;

  localparam logic [2:0] IO_IDX  = 3'd7;
  localparam int         OPC_LSB = 6;
  localparam int         SRC_LSB = 3;
  localparam int         DST_LSB = 0;
  localparam int         IMM_W   = 6;

endpackage

// File: rtl/bus_core_seq_if.sv
// rtl/bus_core_seq_if.sv - ROM fetch and I/O handshake bundle of bus_core_seq
interface bus_core_seq_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              run;
  logic [PC_W-1:0]   code_addr_out;
  logic [7:0]        code_in;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  run, code_in, in_data, in_valid, out_ready,
    output code_addr_out, in_ready, out_data, out_valid
  );

  modport slave (
    output run, code_in, in_data, in_valid, out_ready,
    input  code_addr_out, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/bus_alu_cond.sv
// rtl/bus_alu_cond.sv - combinational ALU and signed jump condition on R3
module bus_alu_cond
  import bus_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_r1,
  input  logic [DATA_W-1:0] i_r2,
  input  logic [DATA_W-1:0] i_r3,
  input  logic [2:0]        i_op,
  input  logic [2:0]        i_cond,
  output logic [DATA_W-1:0] o_alu,
  output logic              o_jump_taken
);
  logic w_zero;
  logic w_neg;

  assign w_zero = (i_r3 == '0);
  assign w_neg  = i_r3[DATA_W-1];

  always_comb begin
    o_alu = '0;
    case (alu_op_e'(i_op))
      ALU_OR:   o_alu = i_r1 | i_r2;
      ALU_NAND: o_alu = ~(i_r1 & i_r2);
      ALU_NOR:  o_alu = ~(i_r1 | i_r2);
      ALU_AND:  o_alu = i_r1 & i_r2;
      ALU_ADD:  o_alu = i_r1 + i_r2;
      ALU_SUB:  o_alu = i_r1 - i_r2;
      ALU_XOR:  o_alu = i_r1 ^ i_r2;
      ALU_XNOR: o_alu = ~(i_r1 ^ i_r2);
    endcase
  end

  always_comb begin
    o_jump_taken = 1'b0;
    case (cond_e'(i_cond))
      CC_NEVER:  o_jump_taken = 1'b0;
      CC_EQ:     o_jump_taken = w_zero;
      CC_LT:     o_jump_taken = w_neg;
      CC_LE:     o_jump_taken = w_neg | w_zero;
      CC_ALWAYS: o_jump_taken = 1'b1;
      CC_NE:     o_jump_taken = ~w_zero;
      CC_GE:     o_jump_taken = ~w_neg;
      CC_GT:     o_jump_taken = ~w_neg & ~w_zero;
    endcase
  end
endmodule

// File: rtl/bus_core_seq.sv
// rtl/bus_core_seq.sv - single-cycle 4-class core with PC, I/O handshakes and stalls
module bus_core_seq
  import bus_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_core_seq_if.master bus
);
  logic [DATA_W-1:0] r_regs [7];
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [PC_W-1:0]   r_pc;

  opcode_e           w_opc;
  logic [2:0]        w_src;
  logic [2:0]        w_dst;
  logic              w_is_copy;
  logic              w_stall_in;
  logic              w_stall_out;
  logic              w_exec;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W-1:0] w_alu;
  logic              w_taken;

  assign w_opc     = opcode_e'(bus.code_in[OPC_LSB +: 2]);
  assign w_src     = bus.code_in[SRC_LSB +: 3];
  assign w_dst     = bus.code_in[DST_LSB +: 3];
  assign w_is_copy = (w_opc == OP_COPY);

  assign w_stall_in  = w_is_copy && (w_src == IO_IDX) && !bus.in_valid;
  assign w_stall_out = w_is_copy && (w_dst == IO_IDX) && r_out_valid && !bus.out_ready;
  assign w_exec      = bus.run && !w_stall_in && !w_stall_out;

  always_comb begin
    w_src_val = bus.in_data;
    if (w_src != IO_IDX) w_src_val = r_regs[w_src];
  end

  bus_alu_cond #(.DATA_W(DATA_W)) u_alu_cond (
    .i_r1         (r_regs[1]),
    .i_r2         (r_regs[2]),
    .i_r3         (r_regs[3]),
    .i_op         (w_dst),
    .i_cond       (w_dst),
    .o_alu        (w_alu),
    .o_jump_taken (w_taken)
  );

  assign bus.in_ready      = bus.run && w_is_copy && (w_src == IO_IDX) && !w_stall_out;
  assign bus.code_addr_out = r_pc;
  assign bus.out_data      = r_out_data;
  assign bus.out_valid     = r_out_valid;

  // Drain is independent of run/stall; an executing COPY to the port overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_exec) begin
        r_pc <= r_pc + PC_W'(1);
        case (w_opc)
          OP_IMM:  r_regs[0] <= DATA_W'(bus.code_in[IMM_W-1:0]);
          OP_ALU:  r_regs[3] <= w_alu;
          OP_COPY: begin
            if (w_dst == IO_IDX) begin
              r_out_data  <= w_src_val;
              r_out_valid <= 1'b1;
            end else begin
              r_regs[w_dst] <= w_src_val;
            end
          end
          OP_JUMP: if (w_taken) r_pc <= PC_W'(r_regs[0]);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_core_seq.sv
// tb/tb_bus_core_seq.sv - self-checking bench for bus_core_seq
module tb_bus_core_seq;
  logic clk;
  logic rst;
  logic [7:0] rom [256];
  int n_checks;
  int n_errors;

  int m_reg [7];
  int m_pc;
  int m_od;
  bit m_ov;

  typedef struct {
    int r1;
    int r2;
    int op;
    int res;
    int cc;
    bit taken;
  } vec_t;
  vec_t vecs [12];

  bus_core_seq_if #(.DATA_W(8), .PC_W(8)) bif ();
  bus_core_seq #(.DATA_W(8), .PC_W(8)) dut (.clk(clk), .rst(rst), .bus(bif));

  assign bif.code_in = rom[bif.code_addr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0: return a | b;
      1: return 255 & ~(a & b);
      2: return 255 & ~(a | b);
      3: return a & b;
      4: return (a + b) & 255;
      5: return (a - b) & 255;
      6: return a ^ b;
      default: return 255 & ~(a ^ b);
    endcase
  endfunction

  function automatic bit cond_ref(input int cc, input int r);
    int s;
    s = (r >= 128) ? r - 256 : r;
    case (cc)
      0: return 1'b0;
      1: return s == 0;
      2: return s < 0;
      3: return s <= 0;
      4: return 1'b1;
      5: return s != 0;
      6: return s >= 0;
      default: return s > 0;
    endcase
  endfunction

  task automatic model_step(input bit run, input bit inv, input int ind, input bit ordy,
                            output bit exp_ir);
    int ins, cls, src, dst, v, npc;
    bit blk_in, blk_out;
    ins = int'(rom[m_pc]);
    cls = ins >> 6;
    src = (ins >> 3) & 7;
    dst = ins & 7;
    blk_in  = (cls == 2) && (src == 7) && !inv;
    blk_out = (cls == 2) && (dst == 7) && m_ov && !ordy;
    exp_ir  = run && (cls == 2) && (src == 7) && !blk_out;
    if (m_ov && ordy) m_ov = 1'b0;
    if (!run || blk_in || blk_out) return;
    npc = (m_pc + 1) % 256;
    case (cls)
      0: m_reg[0] = ins & 63;
      1: m_reg[3] = alu_ref(dst, m_reg[1], m_reg[2]);
      2: begin
        v = (src == 7) ? ind : m_reg[src];
        if (dst == 7) begin
          m_od = v;
          m_ov = 1'b1;
        end else begin
          m_reg[dst] = v;
        end
      end
      default: if (cond_ref(dst, m_reg[3])) npc = m_reg[0] % 256;
    endcase
    m_pc = npc;
  endtask

  task automatic cycle(input bit run, input bit inv, input int ind, input bit ordy);
    bit exp_ir;
    @(negedge clk);
    bif.run       = run;
    bif.in_valid  = inv;
    bif.in_data   = 8'(ind);
    bif.out_ready = ordy;
    #1;
    model_step(run, inv, ind, ordy, exp_ir);
    check("in_ready", int'(bif.in_ready), int'(exp_ir));
    @(posedge clk);
    #1;
    check("pc", int'(bif.code_addr_out), m_pc);
    check("out_valid", int'(bif.out_valid), int'(m_ov));
    check("out_data", int'(bif.out_data), m_od);
  endtask

  task automatic do_reset(input bit run, input bit ordy);
    @(negedge clk);
    rst           = 1'b1;
    bif.run       = run;
    bif.in_valid  = 1'b0;
    bif.out_ready = ordy;
    @(posedge clk);
    #1;
    m_pc = 0;
    m_od = 0;
    m_ov = 1'b0;
    for (int i = 0; i < 7; i++) m_reg[i] = 0;
    check("rst_pc", int'(bif.code_addr_out), 0);
    check("rst_out_valid", int'(bif.out_valid), 0);
    check("rst_out_data", int'(bif.out_data), 0);
    check("rst_in_ready", int'(bif.in_ready), 0);
    rst = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bif.run = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.out_ready = 1'b0;
    rom_clear();

    vecs[0]  = '{8'h03, 8'h05, 5, 8'hFE, 2, 1'b1};
    vecs[1]  = '{8'h03, 8'h05, 5, 8'hFE, 6, 1'b0};
    vecs[2]  = '{8'hF0, 8'h0F, 0, 8'hFF, 2, 1'b1};
    vecs[3]  = '{8'hF0, 8'h0F, 1, 8'hFF, 7, 1'b0};
    vecs[4]  = '{8'hAA, 8'h55, 2, 8'h00, 1, 1'b1};
    vecs[5]  = '{8'hAA, 8'h0F, 3, 8'h0A, 7, 1'b1};
    vecs[6]  = '{8'hFF, 8'h01, 4, 8'h00, 3, 1'b1};
    vecs[7]  = '{8'h80, 8'h01, 5, 8'h7F, 3, 1'b0};
    vecs[8]  = '{8'h5A, 8'h5A, 6, 8'h00, 5, 1'b0};
    vecs[9]  = '{8'h5A, 8'hA5, 7, 8'h00, 0, 1'b0};
    vecs[10] = '{8'h7F, 8'h01, 4, 8'h80, 4, 1'b1};
    vecs[11] = '{8'h00, 8'h01, 5, 8'hFF, 5, 1'b1};

    // Program sum, with a run=0 bubble in the middle
    rom_clear();
    rom[0] = 8'h05; rom[1] = 8'h81; rom[2] = 8'h14; rom[3] = 8'h82; rom[4] = 8'h44; rom[5] = 8'h9F;
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("t1_freeze_pc", int'(bif.code_addr_out), 2);
    for (int i = 2; i < 5; i++) begin
      cycle(1, 0, 0, 1);
      check("t1_pc", int'(bif.code_addr_out), i + 1);
    end
    cycle(1, 0, 0, 1);
    check("t1_sum", int'(bif.out_data), 8'h19);

    // ALU and jump-condition vectors
    for (int i = 0; i < 12; i++) begin
      rom_clear();
      rom[0] = 8'hB9; rom[1] = 8'hBA; rom[2] = 8'(64 + vecs[i].op);
      rom[3] = 8'h10; rom[4] = 8'(192 + vecs[i].cc); rom[5] = 8'h9F; rom[16] = 8'h9F;
      do_reset(1'b0, 1'b1);
      cycle(1, 1, vecs[i].r1, 1);
      cycle(1, 1, vecs[i].r2, 1);
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 1);
      check("vec_jump_pc", int'(bif.code_addr_out), vecs[i].taken ? 16 : 5);
      cycle(1, 1, 0, 1);
      check("vec_alu_res", int'(bif.out_data), vecs[i].res);
      check("vec_out_valid", int'(bif.out_valid), 1);
    end

    // Input stall
    rom_clear();
    rom[0] = 8'hB9; rom[1] = 8'h8F;
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1);
      check("t3_stall_pc", int'(bif.code_addr_out), 0);
      check("t3_stall_in_ready", int'(bif.in_ready), 1);
    end
    cycle(1, 1, 8'hA5, 1);
    check("t3_pc_adv", int'(bif.code_addr_out), 1);
    cycle(1, 0, 0, 1);
    check("t3_r1", int'(bif.out_data), 8'hA5);

    // Output stall, then release with coincident load
    rom_clear();
    rom[0] = 8'h2A; rom[1] = 8'h81; rom[2] = 8'h8F; rom[3] = 8'h15; rom[4] = 8'h87;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    check("t4_first_valid", int'(bif.out_valid), 1);
    check("t4_first_data", int'(bif.out_data), 8'h2A);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0);
      check("t4_stall_pc", int'(bif.code_addr_out), 4);
      check("t4_stall_data", int'(bif.out_data), 8'h2A);
    end
    cycle(1, 0, 0, 1);
    check("t4_second_data", int'(bif.out_data), 8'h15);
    check("t4_second_valid", int'(bif.out_valid), 1);
    check("t4_pc", int'(bif.code_addr_out), 5);
    cycle(1, 0, 0, 1);
    check("t4_drained", int'(bif.out_valid), 0);

    // Reset while stalled with a pending output; then read back R0..R6
    rom[5] = 8'h87;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    check("t6_pre_stall_valid", int'(bif.out_valid), 1);
    do_reset(1'b1, 1'b0);
    for (int r = 0; r < 7; r++) rom[r] = 8'(128 + r * 8 + 7);
    for (int r = 0; r < 7; r++) begin
      cycle(1, 0, 0, 1);
      check("t6_reg_zero", int'(bif.out_data), 0);
    end

    // PC wrap over a ROM of IMMs, with a freeze
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 63));
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
        check("t5_freeze_pc", int'(bif.code_addr_out), 100);
      end
      cycle(1, 0, 0, 1);
    end
    check("t5_wrap_pc", int'(bif.code_addr_out), 0);

    // Random programs and handshakes against the model
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      if (i % 500 == 499) for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bus_core_seq.md
Name: bus_core_seq

Overview:
- Clocked, parametrised successor to the 8-bit pulse-driven bus datapath.
- Fetches one 8-bit instruction per cycle from an asynchronous program ROM and executes the 4-class ISA: immediate, ALU, copy and conditional jump.
- The register file is generalised to DATA_W bits.
- Adds a program counter, input ready/valid and output valid/ready handshakes, and stall logic.
- Sits between the program ROM and the external I/O ports.

Parameters:
- DATA_W, 8, register/bus width; must be >= 6.
- PC_W, 8, program counter width; sets ROM address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  execute enable; 0 freezes all state.
- code_addr_out  output  PC_W  current PC, drives ROM address.
- code_in  input  8  instruction at code_addr_out, valid same cycle.
- in_data  input  DATA_W  external input data.
- in_valid  input  1  in_data valid.
- in_ready  output  1  core consumes in_data this cycle.
- out_data  output  DATA_W  output port register.
- out_valid  output  1  out_data holds an unconsumed value.
- out_ready  input  1  sink accepts out_data.

Behaviour:
Reset and register file
- Reset: PC=0, R0..R6=0, out_data=0, out_valid=0, in_ready=0. Reset wins over every other event.
- Registers R0..R6 are DATA_W wide. Index 7 is the I/O port: as a source it is in_data, as a destination it is out_data.

Decode
- Opcode is code_in[7:6]:
  - 00 IMM: R0 <= zero-extend(code_in[5:0]).
  - 01 ALU: R3 <= f(R1,R2), with op = code_in[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (R1-R2), 6 XOR, 7 XNOR. ADD/SUB are modulo 2^DATA_W; no flags.
  - 10 COPY: dst = code_in[2:0], src = code_in[5:3]. Source is read before destination is written, so src==dst is a no-op write.
  - 11 JUMP: cond on R3 as signed, code_in[2:0]: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
    - Taken: PC <= R0, truncated or zero-extended to PC_W.
    - Not taken: PC <= PC+1.
- All non-jump instructions: PC <= PC+1. PC wraps from 2^PC_W-1 to 0.

Timing and stalls
- Execution is single-cycle: the result is visible in the register file and PC the cycle after the edge.
- stall_in = COPY with src 7 and !in_valid.
- stall_out = COPY with dst 7 and out_valid and !out_ready.
- If run=0 or either stall is active: nothing is written and PC holds. The out_valid drain still proceeds.

Handshakes
- in_ready = run & COPY & src==7 & !stall_out, asserted combinationally. Data is consumed only when in_valid & in_ready.
- Output handshake:
  - out_valid is cleared on out_valid & out_ready.
  - A COPY to dst 7 that executes loads out_data and sets out_valid=1.
  - If that COPY coincides with out_ready, the old value is consumed and the new one loaded; out_valid stays 1.
- COPY 7->7 needs both conditions; there is no partial transfer.

Misc
- run deasserted mid-stall has no side effects.
- Reset during a pending output drops it: out_valid goes to 0.

Decomposition:
- Package bus_core_pkg holds:
  - opcode constants OP_IMM/OP_ALU/OP_COPY/OP_JUMP;
  - ALU op codes;
  - condition codes;
  - IO_IDX=7;
  - the 8-bit instruction field positions.
- One sub-module, bus_alu_cond, is purely combinational:
  - inputs R1, R2, R3, op and cond;
  - outputs alu result and jump_taken;
  - parametrised by DATA_W.

Test Plan:
1. Reset, then ROM {0x05 IMM, 0x81 COPY R0->R1, 0x14 IMM, 0x82 COPY R0->R2, 0x44 ADD} -> R3=0x19 after cycle 5; code_addr_out 0,1,2,3,4,5.
2. DATA_W=8, R1=0x03, R2=0x05, op SUB -> R3=0xFE. Then JUMP cond 2 (<0) with R0=0x10 -> next code_addr_out=0x10. With cond 6 instead -> PC+1.
3. COPY 7->1 with in_valid low for 3 cycles -> PC frozen and in_ready high for those cycles. in_valid high with 0xA5 -> R1=0xA5 and PC advances the next cycle.
4. Two back-to-back COPY 1->7 with out_ready=0 -> first sets out_valid, second stalls. Raising out_ready -> second value loads in the same cycle and out_valid stays 1.
5. PC_W=4 and a run of 16 IMM instructions -> PC wraps from 15 to 0. Toggling run=0 mid-sequence freezes PC and registers.
6. Assert rst while a stall and a pending output exist -> next cycle PC=0, out_valid=0, all registers 0.
